// File: rtl/lamp_pkg.sv
// lamp_pkg: shared widths and FSM states for the lamp state encoder
package lamp_pkg;
    localparam int N_LAMPS = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 5;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/lamp_state_encoder.sv
// lamp_state_encoder: serial scan of a lamp vector into count, top index and one-hot flag
module lamp_state_encoder
    import lamp_pkg::*;
#(
    parameter int N_LAMPS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [N_LAMPS-1:0]  lights_state,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    active_lights,
    output logic [IDX_W-1:0]    top_index,
    output logic                onehot
);
    state_t               state;
    logic [N_LAMPS-1:0]   shadow;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     top_acc, top_n, idx;
    logic                 hit;

    always_comb begin
        hit   = shadow[idx];
        cnt_n = cnt + CNT_W'(hit);
        top_n = hit ? idx : top_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            shadow        <= '0;
            cnt           <= '0;
            top_acc       <= '0;
            idx           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            active_lights <= '0;
            top_index     <= '0;
            onehot        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shadow  <= lights_state;
                        cnt     <= '0;
                        top_acc <= '0;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    cnt     <= cnt_n;
                    top_acc <= top_n;
                    idx     <= idx + 1'b1;
                    if (idx == IDX_W'(N_LAMPS - 1)) begin
                        active_lights <= cnt_n;
                        top_index     <= top_n;
                        onehot        <= (cnt_n == CNT_W'(1));
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lamp_state_encoder.sv
// tb_lamp_state_encoder: scoreboard-driven directed bench for lamp_state_encoder
module tb_lamp_state_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] lights_state = '0;
    logic        busy, done, onehot;
    logic [4:0]  active_lights;
    logic [3:0]  top_index;

    typedef struct {
        logic [4:0]  cnt;
        logic [3:0]  top;
        logic        oh;
        logic [15:0] pat;
    } exp_t;

    exp_t sb[$];
    int   done_cycs[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    lamp_state_encoder #(.N_LAMPS(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lights_state(lights_state),
        .busy(busy), .done(done), .active_lights(active_lights),
        .top_index(top_index), .onehot(onehot)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [15:0] p);
        exp_t e;
        logic found;
        e.cnt = '0;
        e.top = '0;
        found = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (p[i]) begin
                e.cnt = e.cnt + 5'd1;
                if (!found) begin
                    e.top = 4'(i);
                    found = 1'b1;
                end
            end
        end
        e.oh  = (e.cnt == 5'd1);
        e.pat = p;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs settle before the rising edge, outputs are sampled on the falling edge
    task automatic step();
        exp_t  e;
        logic [15:0] dec;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (done) begin
            done_cycs.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("active_lights", 32'(active_lights), 32'(e.cnt));
                chk("top_index", 32'(top_index), 32'(e.top));
                chk("onehot", 32'(onehot), 32'(e.oh));
                if (e.oh) begin
                    dec = 16'd1 << top_index;
                    chk("decode_roundtrip", 32'(dec), 32'(e.pat));
                end
            end
        end
    endtask

    task automatic run(input logic [15:0] p);
        int n;
        start = 1'b1;
        lights_state = p;
        sb.push_back(model(p));
        step();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        n = 0;
        while (!done && n < 40) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd16);
        chk("busy_at_done", 32'(busy), 32'd0);
        step();
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_active"}, 32'(active_lights), 32'd0);
        chk({tag, "_top"}, 32'(top_index), 32'd0);
        chk({tag, "_onehot"}, 32'(onehot), 32'd0);
    endtask

    initial begin
        int t0, n, d0;
        #12;
        chk_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        run(16'h0000);
        run(16'h0200);
        run(16'hFFFF);
        run(16'h8421);

        // Input changes and a stray start during the scan must not disturb the result
        start = 1'b1;
        lights_state = 16'h00F0;
        sb.push_back(model(16'h00F0));
        step();
        start = 1'b0;
        d0 = done_cycs.size();
        for (int k = 1; k <= 16; k++) begin
            chk("busy_hold", 32'(busy), 32'd1);
            if (k == 3) begin
                chk("result_hold_cnt", 32'(active_lights), 32'd4);
                chk("result_hold_top", 32'(top_index), 32'd15);
            end
            if (k == 5) lights_state = 16'hFFFF;
            start = (k == 8);
            step();
        end
        start = 1'b0;
        chk("scan_done", 32'(done), 32'd1);
        repeat (20) step();
        chk("single_done", 32'(done_cycs.size() - d0), 32'd1);

        // Reset in the middle of a scan clears everything immediately
        start = 1'b1;
        lights_state = 16'hFFFF;
        sb.push_back(model(16'hFFFF));
        step();
        start = 1'b0;
        repeat (10) step();
        chk("busy_pre_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        run(16'h0001);

        // Start held high gives back-to-back scans every 18 cycles
        done_cycs.delete();
        start = 1'b1;
        lights_state = 16'h0003;
        repeat (3) sb.push_back(model(16'h0003));
        step();
        t0 = cyc;
        repeat (39) step();
        start = 1'b0;
        chk("b2b_count", 32'(done_cycs.size()), 32'd2);
        if (done_cycs.size() >= 2) begin
            chk("b2b_first", 32'(done_cycs[0] - t0), 32'd16);
            chk("b2b_second", 32'(done_cycs[1] - t0), 32'd34);
        end
        n = 0;
        while (sb.size() > 0 && n < 40) begin
            step();
            n++;
        end
        chk("drain", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lamp_state_encoder.md
LAMP_STATE_ENCODER -- requirements
Module: lamp_state_encoder

Interface
REQ-001 Parameter N_LAMPS, default 16, is the number of lamp state bits scanned; only 16 is supported.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to encode the current lights_state; sampled only in IDLE.
REQ-005 lights_state  input  16  lamp on/off vector; bit i high means lamp i is on.
REQ-006 busy  output  1  high while a scan is in progress (SCAN state).
REQ-007 done  output  1  one-cycle pulse; result outputs are valid from this cycle onward.
REQ-008 active_lights  output  5  number of lamps on, 0..16.
REQ-009 top_index  output  4  highest-numbered lamp that is on; 0 if none are on.
REQ-010 onehot  output  1  high when exactly one lamp is on (top_index is then the exact inverse of a 4-to-16 decode).

Function
REQ-011 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-012 IDLE with start=1 at edge E0: capture lights_state into a shadow register, clear the accumulators and the bit index, go to SCAN, and raise busy.
REQ-013 SCAN: at each of edges E1..E16, examine shadow bit idx (0 to 15 ascending); if the bit is 1, increment the count and set the running top index to idx; then increment idx.
REQ-014 At E16, after bit 15 is processed: load active_lights, top_index and onehot from the final accumulator values, go to DONE, drop busy and raise done.
REQ-015 DONE: at the next edge, drop done and return to IDLE; total latency is 16 cycles from the start edge to the done-high cycle.
REQ-016 The count accumulator SHALL be 5 bits wide so that 16 lamps on gives 5'b10000 without wrap; the 4-bit bit index wraps 15 to 0 with no effect on results.
REQ-017 onehot = (final count == 1).
REQ-018 start while in SCAN or DONE SHALL be ignored; it is not queued.
REQ-019 Changes on lights_state after E0 SHALL NOT affect the current result.
REQ-020 Result outputs SHALL hold their values between done pulses; they change only at the done edge.
REQ-021 start held high continuously SHALL yield back-to-back scans with done every 18 cycles (E0, 16 scan edges, DONE, re-sample in IDLE).
REQ-022 All-zero input SHALL give active_lights=0, top_index=0, onehot=0.

Reset
REQ-023 rst_n low at any time, including mid-scan, SHALL immediately force IDLE with busy=0, done=0, active_lights=0, top_index=0, onehot=0, and clear the shadow register and accumulators.
REQ-024 The first start SHALL be accepted at the first rising edge after rst_n deasserts.

Structure
REQ-025 A shared package lamp_pkg SHALL hold N_LAMPS=16, IDX_W=4, CNT_W=5 and the FSM state enumeration (IDLE, SCAN, DONE).
REQ-026 The block SHALL be a single module with no sub-modules; the FSM, shadow register, accumulators and output registers are all local.

Verification
REQ-027 Reset then start with lights_state=16'h0000 -> done 16 cycles later; active_lights=0, top_index=0, onehot=0.
REQ-028 Start with 16'h0200 -> active_lights=1, top_index=9, onehot=1; feeding top_index into the team's 4x16 decoder reproduces 16'h0200.
REQ-029 Start with 16'hFFFF -> active_lights=16 (5'b10000), top_index=15, onehot=0; then 16'h8421 -> active_lights=4, top_index=15, onehot=0.
REQ-030 Start with 16'h00F0, change lights_state to 16'hFFFF at cycle 5, and pulse start at cycle 8 -> result is still active_lights=4, top_index=7, there is a single done pulse, and busy stays high through cycle 16.
REQ-031 Assert rst_n low at cycle 10 of a scan of 16'hFFFF -> all outputs 0 immediately; a new start with 16'h0001 after reset gives active_lights=1, top_index=0, onehot=1.
REQ-032 start held high for 40 cycles with 16'h0003 -> done at cycles 16 and 34, each with active_lights=2, top_index=1.
